// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream reset domains one at a time: hold, release, then
// wait (bounded) for that domain's ready before moving on. Software can restart it.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 256
) (
    input  logic                  target_clk,
    input  logic                  target_rst,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  seq_timeout,
    output logic [1:0]            seq_state
);

    localparam int CNT_MAX = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]      IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGES_ALL = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] STAGES_NONE = {NUM_STAGES{1'b0}};
    localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
    logic                    done_q, done_d;
    logic                    timeout_q, timeout_d;

    logic [NUM_STAGES-1:0]   sel_s;
    logic                    ack_s;
    logic                    hold_end_s;
    logic                    ack_end_s;
    logic                    last_s;

    // Decode of the stage currently being sequenced; other ack bits never reach the FSM.
    always_comb begin
        sel_s      = STAGE_ONE << idx_q;
        ack_s      = |(stage_ack & sel_s);
        hold_end_s = (cnt_q == HOLD_LAST);
        ack_end_s  = (cnt_q == ACK_LAST);
        last_s     = (idx_q == IDX_LAST);
    end

    // Next-state and next-output logic; a software request behaves exactly like reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        done_d      = done_q;
        timeout_d   = timeout_q;

        if (sw_rst_req) begin
            state_d     = ST_HOLD;
            cnt_d       = CNT_ZERO;
            idx_d       = IDX_ZERO;
            stage_rst_d = STAGES_ALL;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_end_s) begin
                        stage_rst_d = stage_rst_q & ~sel_s;
                        cnt_d       = CNT_ZERO;
                        state_d     = ST_WAIT_ACK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_s || ack_end_s) begin
                        // An ack arriving on the timeout edge still counts as a clean ack.
                        if (ack_s) begin
                            timeout_d = timeout_q;
                        end else begin
                            timeout_d = 1'b1;
                        end
                        cnt_d = CNT_ZERO;
                        if (last_s) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    stage_rst_d = STAGES_NONE;
                    done_d      = 1'b1;
                end
                default: begin
                    state_d     = ST_HOLD;
                    cnt_d       = CNT_ZERO;
                    idx_d       = IDX_ZERO;
                    stage_rst_d = STAGES_ALL;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset from the reset generator.
    always_ff @(posedge target_clk) begin
        if (target_rst) begin
            state_q     <= ST_HOLD;
            cnt_q       <= CNT_ZERO;
            idx_q       <= IDX_ZERO;
            stage_rst_q <= STAGES_ALL;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stage_rst   = stage_rst_q;
    assign seq_done    = done_q;
    assign seq_timeout = timeout_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each restart pushes the expected timeline of
// stage releases; a negedge monitor pops and compares entries as their cycle arrives.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       target_rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] stage_ack = 4'b0000;
    logic [3:0] stage_rst;
    logic       seq_done;
    logic       seq_timeout;
    logic [1:0] seq_state;

    reset_sequencer #(
        .NUM_STAGES (4),
        .HOLD_CYCLES(16),
        .ACK_TIMEOUT(256)
    ) dut (
        .target_clk (clk),
        .target_rst (target_rst),
        .sw_rst_req (sw_rst_req),
        .stage_ack  (stage_ack),
        .stage_rst  (stage_rst),
        .seq_done   (seq_done),
        .seq_timeout(seq_timeout),
        .seq_state  (seq_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        int         tag;
        logic [3:0] rst;
        logic       done;
        logic       tmo;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   scn = 0;

    // ack driver configuration: delay after release, forced-high and stray overlays
    int   ack_dly[4] = '{3, 3, 3, 3};
    logic [3:0] ack_force = 4'b0000;
    logic [3:0] ack_stray = 4'b0000;
    int   since[4] = '{-1, -1, -1, -1};

    // expected timeline parameters: WAIT_ACK edges per stage, stages that time out
    int   wait_len[4] = '{4, 4, 4, 4};
    logic [3:0] to_mask = 4'b0000;

    localparam int NEVER = 1000000;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Ack driver: reacts to observed releases, changes inputs away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (stage_rst[i] !== 1'b0) since[i] = -1;
            else since[i] = since[i] + 1;
            stage_ack[i] = ack_force[i] | ack_stray[i] | (since[i] >= 0 && since[i] >= ack_dly[i]);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            check_eq($sformatf("s%0d_p%0d_rst", e.tag / 1000, e.tag % 1000), {28'd0, stage_rst}, {28'd0, e.rst});
            check_eq($sformatf("s%0d_p%0d_done", e.tag / 1000, e.tag % 1000), {31'd0, seq_done}, {31'd0, e.done});
            check_eq($sformatf("s%0d_p%0d_tmo", e.tag / 1000, e.tag % 1000), {31'd0, seq_timeout}, {31'd0, e.tmo});
            check_eq($sformatf("s%0d_p%0d_state", e.tag / 1000, e.tag % 1000), {30'd0, seq_state}, {30'd0, e.st});
        end
    end

    task automatic push(input int c, input int point, input logic [3:0] r, input logic d,
                        input logic t, input logic [1:0] s);
        exp_t e;
        e.cyc = c; e.tag = scn * 1000 + point; e.rst = r; e.done = d; e.tmo = t; e.st = s;
        sb.push_back(e);
    endtask

    // Expected timeline from the restart edge; nstop < 4 plans only up to that stage's release.
    task automatic plan(input int base, input int nstop, output int last);
        logic [3:0] r;
        logic       tmo;
        int         t, f, a;
        push(base, 0, 4'b1111, 1'b0, 1'b0, 2'd0);
        t = base; tmo = 1'b0; last = base;
        for (int i = 0; i < 4 && i <= nstop; i++) begin
            f = t + 16;
            r = 4'b1111 << i;
            push(f - 1, 10 * i + 1, r, 1'b0, tmo, 2'd0);
            r = 4'b1111 << (i + 1);
            push(f, 10 * i + 2, r, 1'b0, tmo, 2'd1);
            last = f;
            if (i < nstop) begin
                a = f + wait_len[i];
                if (to_mask[i]) tmo = 1'b1;
                push(a, 10 * i + 3, r, (i == 3), tmo, (i == 3) ? 2'd2 : 2'd0);
                t = a; last = a;
            end
        end
        if (nstop >= 4) begin
            push(t + 5, 99, 4'b0000, 1'b1, tmo, 2'd2);
            last = t + 5;
        end
    endtask

    // Called just after an active edge; kind 0 = target_rst, 1 = sw_rst_req, 2 = both.
    task automatic restart(input int kind, output int base);
        target_rst = (kind != 1);
        sw_rst_req = (kind != 0);
        @(posedge clk); #2;
        target_rst = 1'b0;
        sw_rst_req = 1'b0;
        base = cyc;
    endtask

    task automatic wait_until(input int c, input int stray_a, input int stray_b);
        while (cyc < c) begin
            @(posedge clk); #2;
            ack_stray = (cyc == stray_a || cyc == stray_b) ? 4'b0100 : 4'b0000;
        end
        ack_stray = 4'b0000;
    endtask

    task automatic nominal_cfg();
        ack_dly   = '{3, 3, 3, 3};
        ack_force = 4'b0000;
        wait_len  = '{4, 4, 4, 4};
        to_mask   = 4'b0000;
    endtask

    task automatic run_full(input int kind, input int stray_off);
        int base, last;
        restart(kind, base);
        plan(base, 4, last);
        if (stray_off > 0) wait_until(last + 1, base + stray_off, base + 17);
        else wait_until(last + 1, -1, -1);
    endtask

    initial begin
        int base, last;
        repeat (3) @(posedge clk);
        #2;

        scn = 1; nominal_cfg();
        run_full(0, 0);

        scn = 2; nominal_cfg();
        ack_dly[1] = NEVER; wait_len[1] = 256; to_mask = 4'b0010;
        run_full(0, 0);

        scn = 4; nominal_cfg();
        run_full(1, 0);

        scn = 3; nominal_cfg();
        ack_dly[0] = 255; wait_len[0] = 256;
        run_full(1, 0);

        scn = 5; nominal_cfg();
        restart(1, base);
        plan(base, 2, last);
        wait_until(last + 1, -1, -1);
        restart(2, base);
        plan(base, 4, last);
        wait_until(last + 1, -1, -1);

        scn = 6; nominal_cfg();
        ack_force = 4'b1111; wait_len = '{1, 1, 1, 1};
        run_full(0, 0);

        scn = 7; nominal_cfg();
        run_full(1, 5);

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
